alu_issue: RTL and testbench

//  Producer side of the ALU interface: decodes a RISC-V instruction into AluOp plus operands A/B,

---
 rtl/alu_issue.sv | 149 ++++++++++++++
 tb/tb_alu_issue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Decode-and-issue stage feeding the ALU: RV32I instruction -> AluOp/A/B/rd behind a 2-entry skid buffer.
// Optional build macro ALU_ISSUE_ILLEGAL_EN: flag undecodable instructions and issue them as zeroed no-ops.
module alu_issue #(
  parameter int n = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [n-1:0] pc,
  input  logic [n-1:0] rs1_data,
  input  logic [n-1:0] rs2_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   AluOp,
  output logic [n-1:0] A,
  output logic [n-1:0] B,
  output logic [4:0]   rd,
  output logic         illegal
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011
  } opcode_e;

  typedef struct packed {
    logic [3:0]   aluop;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic [4:0]   rd;
    logic         illegal;
  } entry_t;

  entry_t dec, e0, e1;
  logic   e0_valid, e1_full, bad;

  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7b5, f7_ok;
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign f7b5  = instr[30];
  assign f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);

  // NOTE: every field of dec gets a default first so the decoder cannot infer latches.
  always_comb begin
    dec       = '0;
    dec.rd    = instr[11:7];
    dec.aluop = 4'b0000;
    bad       = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        dec.aluop = {f3, f7b5};
        dec.a     = rs1_data;
        dec.b     = rs2_data;
        bad       = !f7_ok || (f7b5 && (f3 != 3'b000) && (f3 != 3'b101));
      end
      OPC_OP_IMM: begin
        dec.a = rs1_data;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.aluop = {f3, f7b5};
          dec.b     = n'(instr[24:20]);
          bad       = !f7_ok;
        end else begin
          // ADDI with instr[30] set must stay ADD, never SUB
          dec.aluop = {f3, 1'b0};
          dec.b     = n'($signed(instr[31:20]));
        end
      end
      OPC_LUI: begin
        dec.a = '0;
        dec.b = n'($signed({instr[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        dec.a = pc;
        dec.b = n'($signed({instr[31:12], 12'b0}));
      end
      OPC_LOAD: begin
        dec.a = rs1_data;
        dec.b = n'($signed(instr[31:20]));
      end
      OPC_STORE: begin
        dec.a = rs1_data;
        dec.b = n'($signed({instr[31:25], instr[11:7]}));
      end
      default: begin
        dec.a = rs1_data;
        dec.b = rs2_data;
        bad   = 1'b1;
      end
    endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
`endif
  end

`ifndef ALU_ISSUE_ILLEGAL_EN
  logic unused_bad;
  assign unused_bad = bad;
`endif

  logic in_xfer, out_xfer;
  assign in_ready = !e1_full;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = e0_valid && out_ready;

  // NOTE: state uses non-blocking assignments; payload is reset too because the outputs must read 0 after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      e0       <= '0;
      e1       <= '0;
      e0_valid <= 1'b0;
      e1_full  <= 1'b0;
    end else if (e1_full) begin
      // in_ready is low, so only a drain of the skid entry can happen
      if (out_xfer) begin
        e0      <= e1;
        e1_full <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!e0_valid || out_ready) begin
        e0       <= dec;
        e0_valid <= 1'b1;
      end else begin
        e1      <= dec;
        e1_full <= 1'b1;
      end
    end else if (out_xfer) begin
      e0_valid <= 1'b0;
    end
  end

  assign out_valid = e0_valid;
  assign AluOp     = e0.aluop;
  assign A         = e0.a;
  assign B         = e0.b;
  assign rd        = e0.rd;
  assign illegal   = e0.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode cases, skid-buffer backpressure and mid-stream reset.
module tb_alu_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instr, pc, rs1_data, rs2_data, A, B;
  logic [3:0]  AluOp;
  logic [4:0]  rd;

  int checks = 0;
  int errors = 0;

  alu_issue #(.n(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .AluOp    (AluOp),
    .A        (A),
    .B        (B),
    .rd       (rd),
    .illegal  (illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one input for a single cycle; on return the outputs reflect the registered result.
  task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                       input logic [31:0] r2);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  logic [31:0] shres;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_aluop", 32'(AluOp), 32'd0);
    check("rst_a", A, 32'd0);
    check("rst_b", B, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    step();

    // sub x2,x1,x2
    issue(32'h4020_8133, 32'h0, 32'd10, 32'd3);
    check("sub_valid", 32'(out_valid), 32'd1);
    check("sub_aluop", 32'(AluOp), 32'b0001);
    check("sub_a", A, 32'd10);
    check("sub_b", B, 32'd3);
    check("sub_rd", 32'(rd), 32'd2);
    step();
    check("sub_drained", 32'(out_valid), 32'd0);

    // srai x1,x1,5
    issue(32'h4050_D093, 32'h0, 32'h8000_0000, 32'h0);
    check("srai_aluop", 32'(AluOp), 32'b1011);
    check("srai_b", B, 32'd5);
    shres = 32'($signed(A) >>> B[4:0]);
    check("srai_result", shres, 32'hFC00_0000);

    // auipc x1,1 followed back-to-back by addi x1,x0,-1 (no bubble)
    issue(32'h0000_1097, 32'h100, 32'h0, 32'h0);
    check("auipc_aluop", 32'(AluOp), 32'b0000);
    check("auipc_a", A, 32'h100);
    check("auipc_b", B, 32'h1000);
    issue(32'hFFF0_0093, 32'h0, 32'h0, 32'h0);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_aluop", 32'(AluOp), 32'b0000);
    check("addi_b", B, 32'hFFFF_FFFF);

    // lui x1,0x80000 ; sw x2,-4(x1)
    issue(32'h8000_00B7, 32'h0, 32'h1234, 32'h0);
    check("lui_a", A, 32'h0);
    check("lui_b", B, 32'h8000_0000);
    issue(32'hFE20_AE23, 32'h0, 32'h40, 32'h0);
    check("sw_a", A, 32'h40);
    check("sw_b", B, 32'hFFFF_FFFC);
    check("sw_aluop", 32'(AluOp), 32'b0000);

    // undecodable word
    issue(32'hFFFF_FFFF, 32'h0, 32'h11, 32'h22);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_aluop", 32'(AluOp), 32'd0);
    check("ill_a", A, 32'd0);
    check("ill_b", B, 32'd0);
    check("ill_rd", 32'(rd), 32'd0);
`else
    check("ill_flag", 32'(illegal), 32'd0);
    check("ill_aluop", 32'(AluOp), 32'd0);
    check("ill_a", A, 32'h11);
    check("ill_b", B, 32'h22);
    check("ill_rd", 32'(rd), 32'd31);
`endif
    step();
    check("ill_drained", 32'(out_valid), 32'd0);

    // backpressure: three back-to-back adds (add x3,x1,x2) tagged by rs1_data
    out_ready = 1'b0;
    instr = 32'h0020_81B3; rs1_data = 32'd1; rs2_data = 32'd0; in_valid = 1'b1;
    check("bp_ready0", 32'(in_ready), 32'd1);
    step();
    check("bp_out1_valid", 32'(out_valid), 32'd1);
    check("bp_out1_a", A, 32'd1);
    check("bp_ready1", 32'(in_ready), 32'd1);
    rs1_data = 32'd2;
    step();
    check("bp_ready2", 32'(in_ready), 32'd0);
    check("bp_held_a", A, 32'd1);
    rs1_data = 32'd3;
    step();
    check("bp_ignored_a", A, 32'd1);
    check("bp_ready3", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_drain_valid", 32'(out_valid), 32'd1);
    check("bp_drain_a", A, 32'd2);
    check("bp_ready4", 32'(in_ready), 32'd1);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);
    issue(32'h0020_81B3, 32'h0, 32'd3, 32'd0);
    check("bp_third_a", A, 32'd3);
    step();

    // reset with both entries full discards them
    out_ready = 1'b0;
    issue(32'h0020_81B3, 32'h0, 32'd5, 32'd0);
    issue(32'h0020_81B3, 32'h0, 32'd6, 32'd0);
    check("mid_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_a", A, 32'd0);
    out_ready = 1'b1;
    step();
    check("mid_stays_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
